// File: rtl/kairo_csr_pkg.sv
// Shared types and constants for the CSR port arbiter/sequencer.
package kairo_csr_pkg;

  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_RW   = 2'b01,
    OP_RS   = 2'b10,
    OP_RC   = 2'b11
  } csr_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_RESP  = 2'b10
  } arb_state_e;

  typedef enum logic {
    GNT_CORE = 1'b0,
    GNT_DBG  = 1'b1
  } grant_e;

  localparam logic [1:0] CSR_RO_BITS    = 2'b11;
  localparam logic [3:0] DBG_CSR_NIBBLE = 4'h0;

endpackage

// File: rtl/kairo_csr_wgen.sv
// Maps a CSR op onto a masked write: data, mask, write enable and illegal-access flag.
module kairo_csr_wgen
  import kairo_csr_pkg::*;
(
  input  csr_op_e     op_i,
  input  logic [31:0] src_i,
  input  logic        nowr_i,
  input  logic [11:0] addr_i,
  output logic [31:0] wdata_o,
  output logic [31:0] mask_o,
  output logic        we_o,
  output logic        err_o
);

  always_comb begin
    wdata_o = '0;
    mask_o  = '0;
    we_o    = 1'b0;
    err_o   = 1'b0;
    unique case (op_i)
      OP_RW: begin
        wdata_o = src_i;
        mask_o  = '1;
        we_o    = 1'b1;
      end
      OP_RS: begin
        wdata_o = '1;
        mask_o  = src_i;
        we_o    = !nowr_i;
      end
      OP_RC: begin
        wdata_o = '0;
        mask_o  = src_i;
        we_o    = !nowr_i;
      end
      default: err_o = 1'b1;
    endcase
    // Reads of the read-only window are legal; only writes there fault.
    if (we_o && (addr_i[11:10] == CSR_RO_BITS)) begin
      err_o = 1'b1;
      we_o  = 1'b0;
    end
  end

endmodule

// File: rtl/kairo_csr_arb.sv
// Arbitrates the single kairo_csr port between the core pipeline and debug,
// sequencing each op as IDLE -> ISSUE (masked write + old-value read) -> RESP.
module kairo_csr_arb
  import kairo_csr_pkg::*;
#(
  parameter bit DEBUG_PRIORITY = 1'b1
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        CORE_REQ,
  input  logic [1:0]  CORE_OP,
  input  logic [11:0] CORE_ADDR,
  input  logic [31:0] CORE_SRC,
  input  logic        CORE_NOWR,
  output logic        CORE_ACK,
  output logic [31:0] CORE_RDATA,
  output logic        CORE_ERR,
  input  logic        DBG_REQ,
  input  logic        DBG_WR,
  input  logic [15:0] DBG_ADDR,
  input  logic [31:0] DBG_WDATA,
  output logic        DBG_ACK,
  output logic [31:0] DBG_RDATA,
  output logic        DBG_ERR,
  output logic [11:0] CSR_ADDR,
  output logic        CSR_WE,
  output logic [31:0] CSR_WDATA,
  output logic [31:0] CSR_WMASK,
  input  logic [31:0] CSR_RDATA,
  output logic        BUSY
);

  arb_state_e  state_q, state_d;
  grant_e      grant_q, last_grant_q;
  logic [11:0] addr_q;
  logic [31:0] wdata_q, mask_q;
  logic        we_q, err_q;
  logic        core_ack_q, core_err_q, dbg_ack_q, dbg_err_q;
  logic [31:0] core_rdata_q, dbg_rdata_q;

  logic        core_elig, dbg_elig, pick_dbg;
  logic        grant_en, resp_en;
  csr_op_e     sel_op;
  logic [31:0] sel_src;
  logic        sel_nowr;
  logic [11:0] sel_addr;
  logic [31:0] gen_wdata, gen_mask;
  logic        gen_we, gen_err, range_err;

  // A requester whose ACK is showing is not re-granted on its still-held REQ.
  assign core_elig = CORE_REQ && !core_ack_q;
  assign dbg_elig  = DBG_REQ && !dbg_ack_q;

  always_comb begin
    if (core_elig && dbg_elig) begin
      pick_dbg = DEBUG_PRIORITY ? 1'b1 : (last_grant_q == GNT_CORE);
    end else begin
      pick_dbg = dbg_elig;
    end
  end

  // Debug accesses reuse the core op encoding: write = RW, read = non-writing RS.
  assign sel_op    = pick_dbg ? (DBG_WR ? OP_RW : OP_RS) : csr_op_e'(CORE_OP);
  assign sel_src   = pick_dbg ? (DBG_WR ? DBG_WDATA : '0) : CORE_SRC;
  assign sel_nowr  = pick_dbg ? !DBG_WR : CORE_NOWR;
  assign sel_addr  = pick_dbg ? DBG_ADDR[11:0] : CORE_ADDR;
  assign range_err = pick_dbg && (DBG_ADDR[15:12] != DBG_CSR_NIBBLE);

  kairo_csr_wgen u_wgen (
    .op_i   (sel_op),
    .src_i  (sel_src),
    .nowr_i (sel_nowr),
    .addr_i (sel_addr),
    .wdata_o(gen_wdata),
    .mask_o (gen_mask),
    .we_o   (gen_we),
    .err_o  (gen_err)
  );

  always_comb begin
    state_d  = state_q;
    grant_en = 1'b0;
    resp_en  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (core_elig || dbg_elig) begin
          state_d  = ST_ISSUE;
          grant_en = 1'b1;
        end
      end
      ST_ISSUE: state_d = ST_RESP;
      ST_RESP: begin
        state_d = ST_IDLE;
        resp_en = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      grant_q      <= GNT_CORE;
      last_grant_q <= GNT_DBG;
      addr_q       <= '0;
      wdata_q      <= '0;
      mask_q       <= '0;
      we_q         <= 1'b0;
      err_q        <= 1'b0;
      core_ack_q   <= 1'b0;
      core_rdata_q <= '0;
      core_err_q   <= 1'b0;
      dbg_ack_q    <= 1'b0;
      dbg_rdata_q  <= '0;
      dbg_err_q    <= 1'b0;
    end else begin
      if (grant_en) begin
        grant_q      <= pick_dbg ? GNT_DBG : GNT_CORE;
        last_grant_q <= pick_dbg ? GNT_DBG : GNT_CORE;
        addr_q       <= sel_addr;
        wdata_q      <= gen_wdata;
        mask_q       <= gen_mask;
        we_q         <= gen_we;
        err_q        <= gen_err || range_err;
      end
      core_ack_q <= resp_en && (grant_q == GNT_CORE);
      dbg_ack_q  <= resp_en && (grant_q == GNT_DBG);
      if (resp_en && (grant_q == GNT_CORE)) begin
        core_rdata_q <= err_q ? '0 : CSR_RDATA;
        core_err_q   <= err_q;
      end
      if (resp_en && (grant_q == GNT_DBG)) begin
        dbg_rdata_q <= err_q ? '0 : CSR_RDATA;
        dbg_err_q   <= err_q;
      end
    end
  end

  assign CSR_ADDR   = addr_q;
  assign CSR_WDATA  = wdata_q;
  assign CSR_WMASK  = mask_q;
  assign CSR_WE     = (state_q == ST_ISSUE) && we_q && !err_q;
  assign BUSY       = (state_q != ST_IDLE);
  assign CORE_ACK   = core_ack_q;
  assign CORE_RDATA = core_rdata_q;
  assign CORE_ERR   = core_err_q;
  assign DBG_ACK    = dbg_ack_q;
  assign DBG_RDATA  = dbg_rdata_q;
  assign DBG_ERR    = dbg_err_q;

endmodule

// File: tb/tb_kairo_csr_arb.sv
// Directed bench for kairo_csr_arb: round-robin instance (index 0) and debug-priority instance (index 1).
module tb_kairo_csr_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_init;

  logic        core_req   [2];
  logic [1:0]  core_op    [2];
  logic [11:0] core_addr  [2];
  logic [31:0] core_src   [2];
  logic        core_nowr  [2];
  logic        core_ack   [2];
  logic [31:0] core_rdata [2];
  logic        core_err   [2];
  logic        dbg_req    [2];
  logic        dbg_wr     [2];
  logic [15:0] dbg_addr   [2];
  logic [31:0] dbg_wdata  [2];
  logic        dbg_ack    [2];
  logic [31:0] dbg_rdata  [2];
  logic        dbg_err    [2];
  logic [11:0] csr_addr   [2];
  logic        csr_we     [2];
  logic [31:0] csr_wdata  [2];
  logic [31:0] csr_wmask  [2];
  logic [31:0] csr_rdata  [2];
  logic        busy       [2];

  logic [31:0] mem [2][4096];

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  always #5 clk = ~clk;

  kairo_csr_arb #(.DEBUG_PRIORITY(1'b0)) u_rr (
    .CLK(clk), .RST_N(rst_n),
    .CORE_REQ(core_req[0]), .CORE_OP(core_op[0]), .CORE_ADDR(core_addr[0]),
    .CORE_SRC(core_src[0]), .CORE_NOWR(core_nowr[0]), .CORE_ACK(core_ack[0]),
    .CORE_RDATA(core_rdata[0]), .CORE_ERR(core_err[0]),
    .DBG_REQ(dbg_req[0]), .DBG_WR(dbg_wr[0]), .DBG_ADDR(dbg_addr[0]),
    .DBG_WDATA(dbg_wdata[0]), .DBG_ACK(dbg_ack[0]), .DBG_RDATA(dbg_rdata[0]),
    .DBG_ERR(dbg_err[0]),
    .CSR_ADDR(csr_addr[0]), .CSR_WE(csr_we[0]), .CSR_WDATA(csr_wdata[0]),
    .CSR_WMASK(csr_wmask[0]), .CSR_RDATA(csr_rdata[0]), .BUSY(busy[0])
  );

  kairo_csr_arb #(.DEBUG_PRIORITY(1'b1)) u_dp (
    .CLK(clk), .RST_N(rst_n),
    .CORE_REQ(core_req[1]), .CORE_OP(core_op[1]), .CORE_ADDR(core_addr[1]),
    .CORE_SRC(core_src[1]), .CORE_NOWR(core_nowr[1]), .CORE_ACK(core_ack[1]),
    .CORE_RDATA(core_rdata[1]), .CORE_ERR(core_err[1]),
    .DBG_REQ(dbg_req[1]), .DBG_WR(dbg_wr[1]), .DBG_ADDR(dbg_addr[1]),
    .DBG_WDATA(dbg_wdata[1]), .DBG_ACK(dbg_ack[1]), .DBG_RDATA(dbg_rdata[1]),
    .DBG_ERR(dbg_err[1]),
    .CSR_ADDR(csr_addr[1]), .CSR_WE(csr_we[1]), .CSR_WDATA(csr_wdata[1]),
    .CSR_WMASK(csr_wmask[1]), .CSR_RDATA(csr_rdata[1]), .BUSY(busy[1])
  );

  // kairo_csr stand-in: registered read of the pre-write value, masked write on the same edge.
  always @(posedge clk) begin
    for (int unsigned g = 0; g < 2; g++) begin
      if (mem_init) begin
        for (int unsigned a = 0; a < 4096; a++) mem[g][a] <= '0;
        mem[g][12'h7B0] <= 32'h4000_8003;
        mem[g][12'hC00] <= 32'h1111_2222;
        csr_rdata[g]    <= '0;
      end else begin
        csr_rdata[g] <= mem[g][csr_addr[g]];
        if (csr_we[g])
          mem[g][csr_addr[g]] <= (mem[g][csr_addr[g]] & ~csr_wmask[g]) |
                                 (csr_wdata[g] & csr_wmask[g]);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  typedef struct {
    bit          is_dbg;
    logic [1:0]  op;      // debug: 01 = write, anything else = read
    logic [15:0] addr;
    logic [31:0] src;
    bit          nowr;
    bit          exp_we;
    logic [31:0] exp_wdata;
    logic [31:0] exp_wmask;
    logic [31:0] exp_rdata;
    bit          exp_err;
    string       name;
  } vec_t;

  function automatic vec_t mk(bit d, logic [1:0] op, logic [15:0] a, logic [31:0] s, bit nw,
                              bit we, logic [31:0] wd, logic [31:0] wm, logic [31:0] rd,
                              bit er, string nm);
    vec_t v;
    v.is_dbg = d; v.op = op; v.addr = a; v.src = s; v.nowr = nw;
    v.exp_we = we; v.exp_wdata = wd; v.exp_wmask = wm; v.exp_rdata = rd;
    v.exp_err = er; v.name = nm;
    return v;
  endfunction

  // One isolated op: CSR_WE in cycle 1, ACK in cycle 3, REQ held until cycle 4.
  task automatic do_op(input int unsigned i, input vec_t v);
    @(negedge clk);
    if (v.is_dbg) begin
      dbg_wr[i] = (v.op == 2'b01); dbg_addr[i] = v.addr; dbg_wdata[i] = v.src; dbg_req[i] = 1'b1;
    end else begin
      core_op[i] = v.op; core_addr[i] = v.addr[11:0]; core_src[i] = v.src;
      core_nowr[i] = v.nowr; core_req[i] = 1'b1;
    end
    @(negedge clk);
    chk({v.name, ".c1_we"}, 32'(csr_we[i]), 32'(v.exp_we));
    chk({v.name, ".c1_addr"}, 32'(csr_addr[i]), 32'(v.addr[11:0]));
    chk({v.name, ".c1_busy"}, 32'(busy[i]), 32'd1);
    if (v.exp_we) begin
      chk({v.name, ".wdata"}, csr_wdata[i], v.exp_wdata);
      chk({v.name, ".wmask"}, csr_wmask[i], v.exp_wmask);
    end
    @(negedge clk);
    chk({v.name, ".c2_we"}, 32'(csr_we[i]), 32'd0);
    chk({v.name, ".c2_ack"}, 32'(v.is_dbg ? dbg_ack[i] : core_ack[i]), 32'd0);
    @(negedge clk);
    chk({v.name, ".c3_ack"}, 32'(v.is_dbg ? dbg_ack[i] : core_ack[i]), 32'd1);
    chk({v.name, ".c3_other_ack"}, 32'(v.is_dbg ? core_ack[i] : dbg_ack[i]), 32'd0);
    chk({v.name, ".rdata"}, v.is_dbg ? dbg_rdata[i] : core_rdata[i], v.exp_rdata);
    chk({v.name, ".err"}, 32'(v.is_dbg ? dbg_err[i] : core_err[i]), 32'(v.exp_err));
    chk({v.name, ".c3_busy"}, 32'(busy[i]), 32'd0);
    @(negedge clk);
    chk({v.name, ".c4_busy"}, 32'(busy[i]), 32'd0);
    chk({v.name, ".c4_we"}, 32'(csr_we[i]), 32'd0);
    chk({v.name, ".c4_ack"}, 32'(v.is_dbg ? dbg_ack[i] : core_ack[i]), 32'd0);
    core_req[i] = 1'b0;
    dbg_req[i]  = 1'b0;
  endtask

  // Both requesters rise together in cycle 0; each drops REQ once its ACK is seen.
  task automatic tie(input int unsigned i, input int exp_core, input int exp_dbg, input string nm);
    int core_c = -1;
    int dbg_c  = -1;
    @(negedge clk);
    core_op[i] = 2'b01; core_addr[i] = 12'h343; core_src[i] = 32'h11; core_nowr[i] = 1'b0;
    dbg_wr[i] = 1'b0; dbg_addr[i] = 16'h0343; dbg_wdata[i] = '0;
    core_req[i] = 1'b1; dbg_req[i] = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (core_ack[i] && core_c < 0) begin core_c = c; core_req[i] = 1'b0; end
      if (dbg_ack[i] && dbg_c < 0) begin dbg_c = c; dbg_req[i] = 1'b0; end
    end
    core_req[i] = 1'b0;
    dbg_req[i]  = 1'b0;
    chk({nm, ".core_ack_cycle"}, 32'(core_c), 32'(exp_core));
    chk({nm, ".dbg_ack_cycle"}, 32'(dbg_c), 32'(exp_dbg));
  endtask

  vec_t vq[$];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    mem_init = 1'b1;
    for (int unsigned i = 0; i < 2; i++) begin
      core_req[i] = 1'b0; core_op[i] = '0; core_addr[i] = '0; core_src[i] = '0; core_nowr[i] = 1'b0;
      dbg_req[i] = 1'b0; dbg_wr[i] = 1'b0; dbg_addr[i] = '0; dbg_wdata[i] = '0;
    end

    //    dbg op     addr      src           nowr we wdata         wmask         rdata         err
    vq.push_back(mk(0, 2'b01, 16'h0340, 32'hDEADBEEF, 0, 1, 32'hDEADBEEF, 32'hFFFFFFFF, 32'h00000000, 0, "rw340_a"));
    vq.push_back(mk(0, 2'b01, 16'h0340, 32'h00000000, 0, 1, 32'h00000000, 32'hFFFFFFFF, 32'hDEADBEEF, 0, "rw340_b"));
    vq.push_back(mk(0, 2'b10, 16'h0304, 32'h00000888, 0, 1, 32'hFFFFFFFF, 32'h00000888, 32'h00000000, 0, "rs304"));
    vq.push_back(mk(0, 2'b11, 16'h0304, 32'h00000000, 1, 0, 32'h0,        32'h0,        32'h00000888, 0, "rc304_nowr"));
    vq.push_back(mk(0, 2'b11, 16'h0304, 32'h00000008, 0, 1, 32'h00000000, 32'h00000008, 32'h00000888, 0, "rc304"));
    vq.push_back(mk(0, 2'b10, 16'h0304, 32'h00000000, 1, 0, 32'h0,        32'h0,        32'h00000880, 0, "rs304_nowr"));
    vq.push_back(mk(0, 2'b01, 16'h0305, 32'h00000000, 1, 1, 32'h00000000, 32'hFFFFFFFF, 32'h00000000, 0, "rw305_nowr"));
    vq.push_back(mk(0, 2'b01, 16'h0F11, 32'h00001234, 0, 0, 32'h0,        32'h0,        32'h00000000, 1, "rw_f11_ro"));
    vq.push_back(mk(0, 2'b10, 16'h0C00, 32'h00000000, 1, 0, 32'h0,        32'h0,        32'h11112222, 0, "rs_c00_read"));
    vq.push_back(mk(0, 2'b00, 16'h0340, 32'h00000005, 0, 0, 32'h0,        32'h0,        32'h00000000, 1, "op_none"));
    vq.push_back(mk(1, 2'b01, 16'h1000, 32'h00000055, 0, 0, 32'h0,        32'h0,        32'h00000000, 1, "dbg_wr_1000"));
    vq.push_back(mk(1, 2'b00, 16'h07B0, 32'h00000000, 0, 0, 32'h0,        32'h0,        32'h40008003, 0, "dbg_rd_dcsr"));
    vq.push_back(mk(1, 2'b01, 16'h0340, 32'hCAFEF00D, 0, 1, 32'hCAFEF00D, 32'hFFFFFFFF, 32'h00000000, 0, "dbg_wr_340"));
    vq.push_back(mk(1, 2'b00, 16'h0340, 32'h00000000, 0, 0, 32'h0,        32'h0,        32'hCAFEF00D, 0, "dbg_rd_340"));
    vq.push_back(mk(1, 2'b01, 16'h0C00, 32'h00000001, 0, 0, 32'h0,        32'h0,        32'h00000000, 1, "dbg_wr_ro"));
    vq.push_back(mk(1, 2'b00, 16'h2340, 32'h00000000, 0, 0, 32'h0,        32'h0,        32'h00000000, 1, "dbg_rd_oos"));

    @(negedge clk);
    @(negedge clk);
    chk("rst.core_ack", 32'(core_ack[0]), 32'd0);
    chk("rst.dbg_ack", 32'(dbg_ack[0]), 32'd0);
    chk("rst.core_rdata", core_rdata[0], 32'd0);
    chk("rst.dbg_rdata", dbg_rdata[0], 32'd0);
    chk("rst.errs", 32'({core_err[0], dbg_err[0]}), 32'd0);
    chk("rst.csr_we", 32'(csr_we[0]), 32'd0);
    chk("rst.csr_addr", 32'(csr_addr[0]), 32'd0);
    chk("rst.csr_wdata", csr_wdata[0], 32'd0);
    chk("rst.csr_wmask", csr_wmask[0], 32'd0);
    chk("rst.busy", 32'(busy[0]), 32'd0);
    mem_init = 1'b0;
    rst_n = 1'b1;

    foreach (vq[k]) do_op(0, vq[k]);

    // Last grant was debug, so the first round-robin tie goes to the core.
    tie(0, 3, 6, "rr_tie1");
    do_op(0, mk(0, 2'b01, 16'h0345, 32'h00000077, 0, 1, 32'h00000077, 32'hFFFFFFFF, 32'h0, 0, "rr_core_only"));
    tie(0, 6, 3, "rr_tie2");
    tie(1, 6, 3, "dp_tie1");
    tie(1, 6, 3, "dp_tie2");

    // Reset landing in ISSUE aborts the op; the held request is then served from scratch.
    @(negedge clk);
    core_op[0] = 2'b01; core_addr[0] = 12'h344; core_src[0] = 32'h00005A5A; core_nowr[0] = 1'b0;
    core_req[0] = 1'b1;
    @(negedge clk);
    chk("rstmid.we_before", 32'(csr_we[0]), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid.we_async", 32'(csr_we[0]), 32'd0);
    chk("rstmid.busy_async", 32'(busy[0]), 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("rstmid.no_ack", 32'(core_ack[0]), 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("rstmid.c1_we", 32'(csr_we[0]), 32'd1);
    chk("rstmid.c1_wdata", csr_wdata[0], 32'h00005A5A);
    @(negedge clk);
    chk("rstmid.c2_ack", 32'(core_ack[0]), 32'd0);
    @(negedge clk);
    chk("rstmid.c3_ack", 32'(core_ack[0]), 32'd1);
    chk("rstmid.rdata", core_rdata[0], 32'h00000000);
    chk("rstmid.err", 32'(core_err[0]), 32'd0);
    core_req[0] = 1'b0;
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
